demux_1x8_8bit_buf: RTL and testbench
=====================================

// Module: demux_1x8_8bit_buf
// PURPOSE
//  Buffered 1-to-N demultiplexer: the distribution-side counterpart of the mux_*x1 selection
//  trees. Accepts one WIDTH-bit word per cycle on a valid/ready input, steers it to output
//  channel in_sel_i, and holds it in that channel's 1-entry register until the consumer takes it.
//  Used to fan a shared byte stream out to independent sinks without losing or duplicating data.
// PARAMETERS
//  WIDTH  8  data width per word / per channel
//  N_OUT  8  number of output channels (1..2**SEL_W)
//  SEL_W  3  width of in_sel_i
// PORTS
//  clk_i        in   1            clock, all state updates on rising edge
//  rst_ni       in   1            reset, synchronous, active-low
//  flush_i      in   1            synchronous flush of all channel buffers
//  in_data_i    in   WIDTH        input word
//  in_sel_i     in   SEL_W        destination channel index
//  in_valid_i   in   1            input word valid
//  in_ready_o   out  1            block can accept input this cycle
//  out_data_o   out  N_OUT*WIDTH  channel k data at [k*WIDTH +: WIDTH]
//  out_valid_o  out  N_OUT        channel k holds a word
//  out_ready_i  in   N_OUT        consumer k takes the word this cycle
//  err_o        out  1            sticky: a word with in_sel_i >= N_OUT was dropped
// BEHAVIOUR
//  - Reset (rst_ni=0 at a clock edge): out_valid_o=0, out_data_o=0, err_o=0. Takes priority
//    over everything, including mid-transfer: in-flight words are discarded.
//  - Per channel k: one data register plus one valid flag. Channel state is EMPTY (valid=0)
//    or FULL (valid=1).
//  - in_ready_o is combinational:
//    flush_i ? 0 : (in_sel_i>=N_OUT ? 1 : (~out_valid_o[in_sel_i] | out_ready_i[in_sel_i])).
//  - Accept = in_valid_i & in_ready_o.
//  - Latency: a word accepted in cycle t appears on out_data_o/out_valid_o[sel] in cycle t+1.
//    There is no combinational path from in_data_i to out_data_o.
//  - Channel k next state:
//    accept to k            -> data<=in_data_i, valid<=1 (covers EMPTY, and FULL being drained
//                              in the same cycle: back-to-back, full throughput, valid stays 1)
//    else out_ready_i[k]&v  -> valid<=0, data held (value don't-care)
//    else                   -> hold
//  - FULL channel with no out_ready_i[k]: in_ready_o=0 only while in_sel_i points at k.
//    Other channels stay unaffected (no head-of-line blocking beyond the current input word).
//  - Channels drain independently: any subset of out_ready_i may be high in one cycle.
//  - out_ready_i[k] while channel k is EMPTY has no effect.
//  - in_sel_i >= N_OUT (only when N_OUT < 2**SEL_W):
//    word accepted and dropped, no channel changes, err_o<=1 at next edge; cleared only by reset.
//  - flush_i=1: all out_valid_o<=0 at next edge; no input accepted that cycle; err_o unchanged.
//    Precedence: reset > flush > accept/drain.
//  - Inputs in_data_i/in_sel_i are sampled only on accept; they may change freely otherwise.
//  - No word is ever duplicated or reordered within a channel.
// TESTING
//  1. Reset: rst_ni=0 for 2 cycles, then release
//     -> out_valid_o=8'h00, out_data_o=0, err_o=0, in_ready_o=1.
//  2. Single word: data=8'hA5, sel=3, valid 1 cycle, all out_ready_i=0
//     -> next cycle out_valid_o=8'h08, ch3 data=8'hA5, held for 10 cycles.
//  3. Backpressure: ch3 FULL, out_ready_i=0, send sel=3 -> in_ready_o=0.
//     Send sel=5 data=8'h3C -> accepted, out_valid_o=8'h28.
//  4. Throughput: stream 8'h00..8'h0F to sel=2 with out_ready_i[2]=1 constantly
//     -> in_ready_o=1 every cycle, ch2 delivers 16 words in order, 1-cycle latency, no gaps.
//  5. Flush/reset mid-operation: fill ch0,ch1,ch7, then flush_i=1 with in_valid_i=1
//     -> in_ready_o=0, out_valid_o=0 next cycle. Repeat with rst_ni=0 -> same plus err_o=0.
//  6. Illegal sel (N_OUT=6): send sel=6 data=8'hFF -> in_ready_o=1, no out_valid_o change,
//     err_o=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/demux_1x8_8bit_buf.sv
// Buffered 1-to-N demultiplexer. Each channel has a 1-entry register. Latency is 1 cycle.
// Input backpressure occurs only when the selected channel is full and is not being drained.
module demux_1x8_8bit_buf #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 8,
    parameter int SEL_W = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       in_data_i,
    input  logic [SEL_W-1:0]       in_sel_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [N_OUT*WIDTH-1:0] out_data_o,
    output logic [N_OUT-1:0]       out_valid_o,
    input  logic [N_OUT-1:0]       out_ready_i,
    output logic                   err_o
);

    logic [WIDTH-1:0] data_q [N_OUT];
    logic [N_OUT-1:0] valid_q;
    logic [N_OUT-1:0] hit;
    logic [N_OUT-1:0] load;
    logic             err_q;
    logic             sel_legal;
    logic             accept;

    // A select at or beyond N_OUT matches no channel, so it is never blocked.
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit[k] = (int'(in_sel_i) == k);
        end
    end

    assign sel_legal  = |hit;
    assign in_ready_o = ~flush_i & ~(|(hit & valid_q & ~out_ready_i));
    assign accept     = in_valid_i & in_ready_o;
    assign load       = {N_OUT{accept}} & hit;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                data_q[k] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            // A load takes precedence over a drain, which keeps a channel full at full throughput.
            valid_q <= load | (valid_q & ~out_ready_i);
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data_i;
                end
            end
            if (accept && !sel_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_data_o[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign out_valid_o = valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_demux_1x8_8bit_buf.sv
// Bench for demux_1x8_8bit_buf. It drives an 8-channel instance and a 6-channel instance
// (the latter for illegal selects) from the same stimulus, against a reference model.
module tb_demux_1x8_8bit_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic [7:0]  out_ready;

    logic        rdy8, rdy6, err8, err6;
    logic [63:0] dat8;
    logic [47:0] dat6;
    logic [7:0]  vld8;
    logic [5:0]  vld6;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    demux_1x8_8bit_buf #(.WIDTH(8), .N_OUT(8), .SEL_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_data_i(in_data),
        .in_sel_i(in_sel), .in_valid_i(in_valid), .in_ready_o(rdy8),
        .out_data_o(dat8), .out_valid_o(vld8), .out_ready_i(out_ready), .err_o(err8)
    );

    demux_1x8_8bit_buf #(.WIDTH(8), .N_OUT(6), .SEL_W(3)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_data_i(in_data),
        .in_sel_i(in_sel), .in_valid_i(in_valid), .in_ready_o(rdy6),
        .out_data_o(dat6), .out_valid_o(vld6), .out_ready_i(out_ready[5:0]), .err_o(err6)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. Each channel either holds one word or is empty.
    // Index 0 is the 8-channel instance and index 1 is the 6-channel instance.
    int         nout [2] = '{8, 6};
    logic       m_full [2][8];
    logic [7:0] m_word [2][8];
    logic       m_err [2];
    logic       model_ok = 1'b0;

    function automatic logic m_ready(int i);
        if (flush) return 1'b0;
        if (int'(in_sel) >= nout[i]) return 1'b1;
        return !m_full[i][in_sel] || out_ready[in_sel];
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) begin
                    m_full[i][k] = 1'b0;
                    m_word[i][k] = 8'h00;
                end
                m_err[i] = 1'b0;
            end else if (flush) begin
                for (int k = 0; k < 8; k++) m_full[i][k] = 1'b0;
            end else begin
                automatic int  tgt = -1;
                if (in_valid && m_ready(i)) begin
                    if (int'(in_sel) < nout[i]) tgt = int'(in_sel);
                    else m_err[i] = 1'b1;
                end
                for (int k = 0; k < nout[i]; k++) begin
                    if (k == tgt) begin
                        m_full[i][k] = 1'b1;
                        m_word[i][k] = in_data;
                    end else if (out_ready[k]) begin
                        m_full[i][k] = 1'b0;
                    end
                end
            end
        end
        if (!rst_n) model_ok = 1'b1;
    end

    // Compare process. Data is checked only on channels that hold a word.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                automatic logic [7:0]  ev  = '0;
                automatic logic [7:0]  av  = (i == 0) ? vld8 : {2'b00, vld6};
                automatic logic [63:0] ad  = (i == 0) ? dat8 : {16'h0, dat6};
                automatic logic        ar  = (i == 0) ? rdy8 : rdy6;
                automatic logic        ae  = (i == 0) ? err8 : err6;
                for (int k = 0; k < nout[i]; k++) ev[k] = m_full[i][k];
                chk($sformatf("cmp%0d in_ready", i), {63'b0, ar}, {63'b0, m_ready(i)});
                chk($sformatf("cmp%0d out_valid", i), {56'b0, av}, {56'b0, ev});
                chk($sformatf("cmp%0d err", i), {63'b0, ae}, {63'b0, m_err[i]});
                for (int k = 0; k < nout[i]; k++) begin
                    if (m_full[i][k])
                        chk($sformatf("cmp%0d ch%0d data", i, k), {56'b0, ad[k*8 +: 8]},
                            {56'b0, m_word[i][k]});
                end
            end
        end
    end

    // Record of the words delivered on channel 2 of the 8-channel instance
    logic      log_en = 1'b0;
    logic [7:0] log_dat [$];
    int         log_cyc [$];

    always @(negedge clk) begin
        if (log_en && vld8[2] && out_ready[2]) begin
            log_dat.push_back(dat8[2*8 +: 8]);
            log_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] sel, input logic [7:0] d);
        in_sel = sel; in_data = d; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_data = 8'h00; in_sel = 3'd0;
        in_valid = 1'b0; out_ready = 8'h00;

        // 1. Reset
        step(2);
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", {56'b0, vld8}, 64'h00);
        chk("reset out_data", dat8, 64'h0);
        chk("reset err", {63'b0, err8}, 64'h0);
        chk("reset in_ready", {63'b0, rdy8}, 64'h1);

        // 2. Single word, held while nobody drains it
        send(3'd3, 8'hA5);
        chk("single out_valid", {56'b0, vld8}, 64'h08);
        chk("single ch3 data", {56'b0, dat8[3*8 +: 8]}, 64'hA5);
        step(10);
        chk("single held valid", {56'b0, vld8}, 64'h08);
        chk("single held data", {56'b0, dat8[3*8 +: 8]}, 64'hA5);

        // 3. Backpressure is limited to the selected full channel
        in_sel = 3'd3; in_data = 8'h77; in_valid = 1'b1;
        #1;
        chk("bp ch3 in_ready", {63'b0, rdy8}, 64'h0);
        step();
        in_sel = 3'd5; in_data = 8'h3C;
        #1;
        chk("bp ch5 in_ready", {63'b0, rdy8}, 64'h1);
        step();
        in_valid = 1'b0;
        chk("bp out_valid", {56'b0, vld8}, 64'h28);
        chk("bp ch3 kept", {56'b0, dat8[3*8 +: 8]}, 64'hA5);
        chk("bp ch5 data", {56'b0, dat8[5*8 +: 8]}, 64'h3C);

        // 4. Full throughput on channel 2
        log_dat.delete(); log_cyc.delete();
        log_en = 1'b1;
        out_ready = 8'h04;
        for (int i = 0; i < 16; i++) begin
            in_sel = 3'd2; in_data = 8'(i); in_valid = 1'b1;
            #1;
            chk($sformatf("stream in_ready %0d", i), {63'b0, rdy8}, 64'h1);
            step();
        end
        in_valid = 1'b0;
        step(2);
        out_ready = 8'h00;
        log_en = 1'b0;
        chk("stream count", 64'(log_dat.size()), 64'd16);
        for (int i = 0; i < 16 && i < log_dat.size(); i++) begin
            chk($sformatf("stream word %0d", i), {56'b0, log_dat[i]}, 64'(i));
            if (i > 0)
                chk($sformatf("stream gap %0d", i), 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);
        end

        // 5a. Flush in the middle of operation
        send(3'd0, 8'h10);
        send(3'd1, 8'h11);
        send(3'd7, 8'h17);
        chk("pre-flush out_valid", {56'b0, vld8}, 64'hAB);
        flush = 1'b1; in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h44;
        #1;
        chk("flush in_ready", {63'b0, rdy8}, 64'h0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", {56'b0, vld8}, 64'h00);

        // 6. Illegal select on the 6-channel instance
        send(3'd4, 8'h44);
        in_sel = 3'd6; in_data = 8'hFF; in_valid = 1'b1;
        #1;
        chk("illegal in_ready", {63'b0, rdy6}, 64'h1);
        step();
        in_valid = 1'b0;
        chk("illegal out_valid6", {58'b0, vld6}, 64'h10);
        chk("illegal err6", {63'b0, err6}, 64'h1);
        chk("legal sel6 on dut8", {56'b0, vld8}, 64'h50);
        chk("legal err8", {63'b0, err8}, 64'h0);
        step(5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("err6 sticky", {63'b0, err6}, 64'h1);

        // 5b. Reset in the middle of operation clears err
        send(3'd0, 8'h20);
        send(3'd7, 8'h27);
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h21;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("rst out_valid", {56'b0, vld8}, 64'h00);
        chk("rst out_data", dat8, 64'h0);
        chk("rst err6", {63'b0, err6}, 64'h0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
